kd_tree_wb_loader: RTL and testbench
====================================

KD_TREE_WB_LOADER -- requirements
Module: kd_tree_wb_loader

Interface
REQ-001 SHALL have parameter INTERNAL_WIDTH, default 22, meaning node word width (median 11 bits low, index 11 bits high).
REQ-002 SHALL have parameter NODE_COUNT, default 63, meaning internal nodes per tree load.
REQ-003 SHALL have parameter WB_ADDRESS_OFFSET, default 494, meaning bus address of node 0.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255, meaning maximum cycles waited for ack per bus cycle.
REQ-005 SHALL have: wb_clk_i  in  1  sole clock; wb_rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have: start  in  1  pulse to begin a load; busy  out  1  load in progress; done  out  1  one-cycle completion pulse; error  out  1  sticky fault flag.
REQ-007 SHALL have: node_valid  in  1; node_data  in  INTERNAL_WIDTH; node_ready  out  1 -- node word stream, transfer when valid and ready are both high.
REQ-008 SHALL have Wishbone initiator ports: wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1; wbm_sel_o  out  4; wbm_adr_o, wbm_dat_o  out  32; wbm_dat_i  in  32; wbm_ack_i  in  1.

Function
REQ-009 SHALL use states IDLE, FETCH, WR_LO, WR_HI, NEXT, FIN, FAULT (plus RD_LO, RD_HI under REQ-022).
REQ-010 IDLE: start moves to FETCH, clears error and node counter; start in any other state is ignored.
REQ-011 FETCH: node_ready high only here; on transfer latch node_data, go to WR_LO.
REQ-012 WR_LO: cyc/stb/we high, adr = WB_ADDRESS_OFFSET + node counter, dat[10:0] = node[10:0], dat[11] = 0, other dat bits 0, sel = 4'hF.
REQ-013 WR_HI: same address, dat[10:0] = node[21:11], dat[11] = 1.
REQ-014 Each bus cycle holds all wbm outputs stable until ack; ack sampled high ends the cycle, cyc/stb drop for exactly one cycle before the next bus cycle.
REQ-015 NEXT: counter increments; if counter reaches NODE_COUNT go to FIN, else FETCH.
REQ-016 FIN: done pulses one cycle, return to IDLE.
REQ-017 Per-cycle ack timer: counts while stb high without ack; at ACK_TIMEOUT cycles abort bus cycle, set error, go to FAULT.
REQ-018 FAULT: all wbm strobes low; stays until start (restart from node 0) or reset.
REQ-019 busy high in every state except IDLE and FAULT; ack arriving while stb low is ignored.
REQ-020 Address arithmetic 32-bit unsigned, no wrap checking; counter width clog2(NODE_COUNT+1).

Reset
REQ-021 On wb_rst_i high at clock edge: state IDLE; busy, done, error, node_ready, cyc, stb, we = 0; adr, dat, sel = 0; counters 0; reset mid-bus-cycle drops cyc/stb the following cycle with no ack wait.

Configuration
REQ-022 With KD_TREE_LOADER_READBACK_EN defined: after WR_HI, RD_LO/RD_HI issue reads (we = 0, dat[11] = 0 then 1, same address); returned wbm_dat_i[10:0] compared to the written half; mismatch sets error and enters FAULT; without the macro, WR_HI goes directly to NEXT and no read cycles exist.

Structure
REQ-023 Shared package kd_tree_pkg SHALL hold the state enum, INTERNAL_WIDTH, NODE_COUNT, WB_ADDRESS_OFFSET and the half-select bit position (11).
REQ-024 SHALL instantiate one sub-module wb_ack_timer (load, count, expire) for REQ-017.

Verification
REQ-025 Start, stream 63 nodes, zero-wait-state ack -> 126 writes, addresses 494..556, done pulse once, error 0.
REQ-026 Node 0 = 22'h2A5F3 -> write 1 dat = 32'h000005F3, write 2 dat = 32'h00000854.
REQ-027 node_valid low 10 cycles between nodes and ack delayed 3 cycles -> no bus activity while waiting, outputs stable until ack, same data.
REQ-028 Ack withheld on node 5 high half -> after 255 cycles stb low, error 1, FAULT; start -> reload from address 494.
REQ-029 Reset asserted during node 20 WR_LO -> next cycle all outputs 0, IDLE, later start loads from node 0.
REQ-030 Readback build, responder corrupts bit 3 of node 7 low read -> error 1, FAULT, no write to address 502.

Source files
------------

// File: rtl/kd_tree_pkg.sv
// Shared types/constants for the kd-tree Wishbone loader; RD_LO/RD_HI exist only with KD_TREE_LOADER_READBACK_EN.
// No logic here: node word layout is {index[21:11], median[10:0]}.
package kd_tree_pkg;

  localparam int INTERNAL_WIDTH    = 22;
  localparam int NODE_COUNT        = 63;
  localparam int WB_ADDRESS_OFFSET = 494;
  localparam int HALF_BIT          = 11;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WR_LO,
    WR_HI,
    NEXT,
    FIN,
    FAULT
`ifdef KD_TREE_LOADER_READBACK_EN
    ,
    RD_LO,
    RD_HI
`endif
  } state_t;

endpackage

// File: rtl/kd_tree_wb_loader_ack_timer.sv
// wb_ack_timer: counts unacknowledged strobe cycles, expire in the TIMEOUT-th one (combinational).
// load clears the count; the count saturates once expired and never stalls the caller.
module wb_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expire = count && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kd_tree_wb_loader.sv
// Streams NODE_COUNT node words into Wishbone as two 11-bit half writes each; node_ready stalls upstream
// until the previous node's bus cycles finish. KD_TREE_LOADER_READBACK_EN adds a verifying read per half.
module kd_tree_wb_loader #(
  parameter int INTERNAL_WIDTH    = kd_tree_pkg::INTERNAL_WIDTH,
  parameter int NODE_COUNT        = kd_tree_pkg::NODE_COUNT,
  parameter int WB_ADDRESS_OFFSET = kd_tree_pkg::WB_ADDRESS_OFFSET,
  parameter int ACK_TIMEOUT       = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  input  logic                      node_valid,
  input  logic [INTERNAL_WIDTH-1:0] node_data,
  output logic                      node_ready,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic [31:0]               wbm_adr_o,
  output logic [31:0]               wbm_dat_o,
  input  logic [31:0]               wbm_dat_i,
  input  logic                      wbm_ack_i
);

  import kd_tree_pkg::*;

  localparam int CW = $clog2(NODE_COUNT + 1);

  state_t                    state, state_nx;
  logic                      bus_act, bus_act_nx;
  logic [INTERNAL_WIDTH-1:0] node_q, node_nx;
  logic [CW-1:0]             cnt, cnt_nx, cnt_inc;
  logic                      err_q, err_nx;
  logic                      in_bus, hi_half, wr_phase;
  logic                      stb, ack, tmo;
  logic [HALF_BIT-1:0]       half_val;
  logic                      unused_dat;

  always_comb begin
    in_bus   = 1'b0;
    hi_half  = 1'b0;
    wr_phase = 1'b0;
    case (state)
      WR_LO: begin in_bus = 1'b1; wr_phase = 1'b1; end
      WR_HI: begin in_bus = 1'b1; wr_phase = 1'b1; hi_half = 1'b1; end
`ifdef KD_TREE_LOADER_READBACK_EN
      RD_LO: in_bus = 1'b1;
      RD_HI: begin in_bus = 1'b1; hi_half = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Every bus state opens with one idle cycle (bus_act low), giving the mandatory cyc/stb gap.
  assign stb      = in_bus & bus_act;
  assign ack      = stb & wbm_ack_i;
  assign half_val = hi_half ? HALF_BIT'(node_q[INTERNAL_WIDTH-1:HALF_BIT]) : node_q[HALF_BIT-1:0];
  assign cnt_inc  = cnt + 1'b1;
  assign unused_dat = ^wbm_dat_i;

  wb_ack_timer #(.TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (~stb),
    .count  (stb & ~wbm_ack_i),
    .expire (tmo)
  );

  always_comb begin
    state_nx   = state;
    bus_act_nx = bus_act;
    node_nx    = node_q;
    cnt_nx     = cnt;
    err_nx     = err_q;
    case (state)
      IDLE, FAULT: begin
        if (start) begin
          state_nx = FETCH;
          cnt_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      FETCH: begin
        if (node_valid) begin
          node_nx  = node_data;
          state_nx = WR_LO;
        end
      end
      NEXT: begin
        cnt_nx   = cnt_inc;
        state_nx = (cnt_inc == CW'(NODE_COUNT)) ? FIN : FETCH;
      end
      FIN: state_nx = IDLE;
      default: begin
        if (!bus_act) begin
          bus_act_nx = 1'b1;
        end else if (ack) begin
          bus_act_nx = 1'b0;
          case (state)
            WR_LO: state_nx = WR_HI;
`ifdef KD_TREE_LOADER_READBACK_EN
            WR_HI: state_nx = RD_LO;
            RD_LO, RD_HI: begin
              if (wbm_dat_i[HALF_BIT-1:0] != half_val) begin
                err_nx   = 1'b1;
                state_nx = FAULT;
              end else begin
                state_nx = (state == RD_LO) ? RD_HI : NEXT;
              end
            end
`endif
            default: state_nx = NEXT;
          endcase
        end else if (tmo) begin
          bus_act_nx = 1'b0;
          err_nx     = 1'b1;
          state_nx   = FAULT;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      bus_act <= 1'b0;
      node_q  <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      bus_act <= bus_act_nx;
      node_q  <= node_nx;
      cnt     <= cnt_nx;
      err_q   <= err_nx;
    end
  end

  assign busy       = (state != IDLE) && (state != FAULT);
  assign done       = (state == FIN);
  assign error      = err_q;
  assign node_ready = (state == FETCH);

  // Address/data are only driven during a live strobe so idle, reset and fault all read as zero.
  assign wbm_cyc_o = stb;
  assign wbm_stb_o = stb;
  assign wbm_we_o  = stb & wr_phase;
  assign wbm_sel_o = stb ? 4'hF : 4'h0;
  assign wbm_adr_o = stb ? (32'(WB_ADDRESS_OFFSET) + 32'(cnt)) : 32'h0;
  assign wbm_dat_o = !stb    ? 32'h0 :
                     wr_phase ? (32'(half_val) | (32'(hi_half) << HALF_BIT)) :
                                (32'(hi_half) << HALF_BIT);

endmodule

// File: tb/tb_kd_tree_wb_loader.sv
// Directed bench for kd_tree_wb_loader: full loads, wait states, ack timeout, reset mid-cycle, readback fault.
module tb_kd_tree_wb_loader;

  localparam int NODES = 63;
  localparam int BASE  = 494;
`ifdef KD_TREE_LOADER_READBACK_EN
  localparam int CYC_PER_NODE = 4;
`else
  localparam int CYC_PER_NODE = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        node_valid = 1'b0;
  logic [21:0] node_data = '0;
  logic        busy, done, error, node_ready, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kd_tree_wb_loader dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .node_valid (node_valid),
    .node_data  (node_data),
    .node_ready (node_ready),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_dat_i  (dat_i),
    .wbm_ack_i  (ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bus responder, all state owned here; the stimulus side only reads counters and queues.
  int          ack_delay    = 0;
  logic [31:0] withhold_adr = 32'hFFFF_FFFF;
  logic [31:0] corrupt_adr  = 32'hFFFF_FFFF;
  int          wait_cnt = 0, run = 0, last_run = 0;
  int          stb_cycles = 0, unstable = 0, done_cnt = 0;
  logic [69:0] snap = '0;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  logic [31:0] mem[int];

  always @(negedge clk) begin
    ack   = 1'b0;
    dat_i = '0;
    if (done) done_cnt++;
    if (stb) begin
      stb_cycles++;
      run++;
      if (wait_cnt == 0) snap = {cyc, we, sel, adr, dat_o};
      else if (snap !== {cyc, we, sel, adr, dat_o}) unstable++;
      if (!(we && dat_o[11] && adr == withhold_adr) && wait_cnt >= ack_delay) begin
        ack = 1'b1;
        wait_cnt = 0;
        if (we) begin
          wr_adr.push_back(adr);
          wr_dat.push_back(dat_o);
          mem[int'(adr) * 2 + int'(dat_o[11])] = dat_o;
        end else begin
          dat_i = mem.exists(int'(adr) * 2 + int'(dat_o[11])) ? mem[int'(adr) * 2 + int'(dat_o[11])] : 32'h0;
          if (adr == corrupt_adr && !dat_o[11]) dat_i = dat_i ^ 32'h8;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      if (run > 0) last_run = run;
      run = 0;
      wait_cnt = 0;
    end
  end

  function automatic logic [21:0] node_val(input int i);
    logic [31:0] h;
    h = (i * 32'h0001_F3D5) ^ 32'h0001_5A3C;
    return (i == 0) ? 22'h2A5F3 : h[21:0];
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic send_node(input int i, input int gap);
    int t;
    repeat (gap) @(posedge clk);
    #1;
    node_valid = 1'b1;
    node_data  = node_val(i);
    t = 0;
    forever begin
      @(negedge clk);
      if (node_ready) break;
      t++;
      if (t > 2000) begin
        check("node_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    node_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int limit);
    int t = 0;
    while (wr_adr.size() < n && t < limit) begin @(negedge clk); t++; end
    check("write_wait", 32'(wr_adr.size() >= n), 32'd1);
  endtask

  // Model: low half {0, median}, high half {1, index}, both at BASE + node index.
  task automatic verify_writes(input int base, input int n, input string tag);
    int bad = 0;
    logic [21:0] v;
    for (int i = 0; i < n; i++) begin
      v = node_val(i);
      if (wr_adr[base + 2*i]     !== 32'(BASE + i)) bad++;
      if (wr_adr[base + 2*i + 1] !== 32'(BASE + i)) bad++;
      if (wr_dat[base + 2*i]     !== {21'h0, 1'b0, v[10:0]}) bad++;
      if (wr_dat[base + 2*i + 1] !== {21'h0, 1'b1, v[21:11]}) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic full_load(input int gap, input int delay, input string tag);
    int wb, sb, ub, db, t;
    ack_delay = delay;
    wb = wr_adr.size(); sb = stb_cycles; ub = unstable; db = done_cnt;
    pulse_start();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < NODES; i++) send_node(i, gap);
    t = 0;
    while (done_cnt == db && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_writes"}, 32'(wr_adr.size() - wb), 32'd126);
    if (wr_adr.size() - wb == 126) begin
      verify_writes(wb, NODES, {tag, "_stream"});
      check({tag, "_first_adr"}, wr_adr[wb], 32'd494);
      check({tag, "_last_adr"}, wr_adr[wb + 125], 32'd556);
      check({tag, "_dat0"}, wr_dat[wb], 32'h0000_05F3);
      check({tag, "_dat1"}, wr_dat[wb + 1], 32'h0000_0854);
    end
    check({tag, "_stb_cycles"}, 32'(stb_cycles - sb), 32'((delay + 1) * CYC_PER_NODE * NODES));
    check({tag, "_stable"}, 32'(unstable - ub), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int wb, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {22'h0, busy, done, error, node_ready, cyc, stb, we, sel[0], sel[3], 1'b0}, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    full_load(0, 0, "zw");
    full_load(10, 3, "ws");

    // Ack withheld on node 5 high half.
    ack_delay = 0;
    withhold_adr = 32'(BASE + 5);
    wb = wr_adr.size();
    pulse_start();
    for (int i = 0; i <= 5; i++) send_node(i, 0);
    t = 0;
    while (!error && t < 600) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_stb_len", 32'(last_run), 32'd255);
    check("tmo_writes", 32'(wr_adr.size() - wb), 32'd11);
    check("fault_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("fault_quiet", {29'h0, cyc, stb, node_ready}, 32'd0);
    withhold_adr = 32'hFFFF_FFFF;
    wb = wr_adr.size();
    pulse_start();
    check("restart_err_clr", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    send_node(0, 0);
    wait_writes(wb + 2, 50);
    if (wr_adr.size() >= wb + 2) begin
      check("restart_adr", wr_adr[wb], 32'd494);
      check("restart_dat_hi", wr_dat[wb + 1], 32'h0000_0854);
    end

    // Reset during node 20 low write.
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    pulse_start();
    for (int i = 0; i <= 20; i++) send_node(i, 0);
    t = 0;
    forever begin
      @(negedge clk);
      if (stb && we && !dat_o[11] && adr == 32'(BASE + 20)) break;
      t++;
      if (t > 50) begin check("rst_wr_lo_timeout", 32'd1, 32'd0); break; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctrl", {25'h0, busy, done, error, node_ready, cyc, stb, we}, 32'd0);
    check("midrst_adr", adr, 32'd0);
    check("midrst_dat_sel", dat_o | 32'(sel), 32'd0);
    rst = 1'b0;
    wb = wr_adr.size();
    pulse_start();
    send_node(0, 0);
    wait_writes(wb + 1, 50);
    if (wr_adr.size() >= wb + 1) check("midrst_reload_adr", wr_adr[wb], 32'd494);

`ifdef KD_TREE_LOADER_READBACK_EN
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    corrupt_adr = 32'(BASE + 7);
    wb = wr_adr.size();
    pulse_start();
    for (int i = 0; i <= 7; i++) send_node(i, 0);
    t = 0;
    while (!error && t < 100) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    check("rb_error", 32'(error), 32'd1);
    check("rb_fault", 32'(busy), 32'd0);
    check("rb_writes", 32'(wr_adr.size() - wb), 32'd16);
    t = 0;
    for (int i = wb; i < wr_adr.size(); i++) if (wr_adr[i] == 32'd502) t++;
    check("rb_no_502", 32'(t), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=expired expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
